// File: rtl/signed_mult8_pkg.sv
// Shared definitions for the signed_mult8 shift-add multiplier.
package signed_mult8_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/signed_mult8_if.sv
// Operand/result handshake bundle for signed_mult8.
interface signed_mult8_if;
  import signed_mult8_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, zero
  );

endinterface

// File: rtl/twos_complement.sv
// Two's complement negation of a WIDTH-bit value.
module twos_complement #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] negated
);

  assign negated = ~value + 1'b1;

endmodule

// File: rtl/signed_mult8.sv
// Multi-cycle 8x8 signed multiplier: magnitude shift-add loop plus a final sign fix.
module signed_mult8 #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  signed_mult8_if.slave bus
);
  import signed_mult8_pkg::*;

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PW-1:0]     acc_q;
  logic [WIDTH-1:0]  ma_q;
  logic [WIDTH-1:0]  mb_q;
  logic              neg_q;
  logic [PW-1:0]     product_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  neg_a;
  logic [WIDTH-1:0]  neg_b;

  twos_complement #(.WIDTH(WIDTH)) u_neg_a (
    .value   (bus.a),
    .negated (neg_a)
  );

  twos_complement #(.WIDTH(WIDTH)) u_neg_b (
    .value   (bus.b),
    .negated (neg_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Negating -128 gives 0x80, which is the correct unsigned magnitude.
            ma_q    <= bus.a[WIDTH-1] ? neg_a : bus.a;
            mb_q    <= bus.b[WIDTH-1] ? neg_b : bus.b;
            neg_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mb_q[0]) begin
            acc_q <= acc_q + (PW'(ma_q) << cnt_q);
          end
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          // Truncation makes a negated zero accumulator come out as zero.
          product_q   <= neg_q ? (~acc_q + 1'b1) : acc_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.zero      = (product_q == '0);

endmodule

// File: tb/tb_signed_mult8.sv
// Randomized self-checking bench for signed_mult8 against a plain a*b reference.
module tb_signed_mult8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  signed_mult8_if bus ();

  signed_mult8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  // Accepts one operand pair (caller guarantees idle), waits for the result and checks it.
  // With out_ready high it also checks the return to idle one cycle later.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi);
    int          n;
    bit          ready_seen;
    logic [15:0] exp;
    exp        = ref_mul(ai, bi);
    n          = 0;
    ready_seen = 1'b0;
    bus.a        = ai;
    bus.b        = bi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    while (!bus.out_valid && n < 20) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd9);
    check({tag, " in_ready low while busy"}, 32'(ready_seen), 32'd0);
    check({tag, " product"}, 32'(bus.product), 32'(exp));
    check({tag, " zero"}, 32'(bus.zero), 32'(exp == 16'h0));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({tag, " out_valid drops"}, 32'(bus.out_valid), 32'd0);
      check({tag, " in_ready returns"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] held;
    int          late_valid;
    logic [7:0]  ra;
    logic [7:0]  rb;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h0;
    bus.b         = 8'h0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset product", 32'(bus.product), 32'h0);
    check("reset zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("7x6", 8'd7, 8'd6);
    run_op("-3x5", 8'hFD, 8'd5);
    run_op("-128x-128", 8'h80, 8'h80);
    run_op("-128x127", 8'h80, 8'h7F);
    run_op("0x-1", 8'h00, 8'hFF);

    // Backpressure: result must hold while new operands are offered.
    bus.out_ready = 1'b0;
    run_op("bp -7x9", 8'hF9, 8'd9);
    held = bus.product;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'($urandom);
      bus.b        = 8'($urandom);
      @(posedge clk);
      #1;
      check("bp out_valid held", 32'(bus.out_valid), 32'd1);
      check("bp product stable", 32'(bus.product), 32'(held));
      check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);

    // Reset during the fourth MUL cycle.
    bus.a        = 8'd10;
    bus.b        = 8'd10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset product", 32'(bus.product), 32'h0);
    check("midreset zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    late_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) late_valid++;
    end
    check("midreset no out_valid", 32'(late_valid), 32'd0);
    run_op("2x3", 8'd2, 8'd3);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rand%0d %0d*%0d", i, $signed(ra), $signed(rb)), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
